// File: rtl/riscv_writeback_pkg.sv
// Shared widths, the rd==0 "no write" encoding and the late-result FIFO entry layout.
// Imported by the writeback interface, the late-result FIFO user and the top.
package riscv_writeback_pkg;

  localparam int REG_W = 5;
  localparam int XLEN  = 32;

  localparam logic [REG_W-1:0] RD_NONE = '0;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  value;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_EXEC,
    SRC_FIFO,
    SRC_BYPASS
  } wb_src_t;

  // A result only counts as a register write when it targets a real register.
  function automatic logic is_write(input logic vld, input logic [REG_W-1:0] rd);
    return vld && (rd != RD_NONE);
  endfunction

endpackage

// File: rtl/riscv_writeback_if.sv
// Writeback stage bundle: exec/late results, issue tracking, operand reads and the rd0 port.
// master = pipeline/regfile side, slave = the writeback stage.
interface riscv_writeback_if;
  import riscv_writeback_pkg::*;

  logic             exec_valid_i;
  logic [REG_W-1:0] exec_rd_i;
  logic [XLEN-1:0]  exec_value_i;
  logic             late_valid_i;
  logic [REG_W-1:0] late_rd_i;
  logic [XLEN-1:0]  late_value_i;
  logic             late_full_o;
  logic             issue_valid_i;
  logic [REG_W-1:0] issue_rd_i;
  logic [REG_W-1:0] ra_i;
  logic [REG_W-1:0] rb_i;
  logic [XLEN-1:0]  rf_ra_value_i;
  logic [XLEN-1:0]  rf_rb_value_i;
  logic [XLEN-1:0]  ra_value_o;
  logic [XLEN-1:0]  rb_value_o;
  logic             ra_busy_o;
  logic             rb_busy_o;
  logic [REG_W-1:0] rd0_o;
  logic [XLEN-1:0]  rd0_value_o;
  logic             overflow_o;

  modport master (
    output exec_valid_i, exec_rd_i, exec_value_i,
    output late_valid_i, late_rd_i, late_value_i,
    output issue_valid_i, issue_rd_i,
    output ra_i, rb_i, rf_ra_value_i, rf_rb_value_i,
    input  late_full_o, ra_value_o, rb_value_o, ra_busy_o, rb_busy_o,
    input  rd0_o, rd0_value_o, overflow_o
  );

  modport slave (
    input  exec_valid_i, exec_rd_i, exec_value_i,
    input  late_valid_i, late_rd_i, late_value_i,
    input  issue_valid_i, issue_rd_i,
    input  ra_i, rb_i, rf_ra_value_i, rf_rb_value_i,
    output late_full_o, ra_value_o, rb_value_o, ra_busy_o, rb_busy_o,
    output rd0_o, rd0_value_o, overflow_o
  );

endinterface

// File: rtl/riscv_wb_fifo.sv
// Generic circular FIFO; head visible combinationally, full flag registered.
// Push while full is accepted only alongside a pop; otherwise it is dropped and flagged.
module riscv_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic             empty,
  output logic             full,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_rdy && (count != '0);
  assign do_push = push_vld && ((count != DEPTH_C) || do_pop);
  assign drop    = push_vld && !do_push;
  assign empty   = (count == '0);
  assign pop_dat = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)
      count_nxt = count + 1'b1;
    else if (!do_push && do_pop)
      count_nxt = count - 1'b1;
  end

  // Power-of-two depth: pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_C);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/riscv_writeback.sv
// Merges exec and long-latency results onto rd0 (exec wins, late results queue), tracks pending
// long-latency writes and forwards rd0 onto operand reads; zero-cycle path, no backpressure.
module riscv_writeback
  import riscv_writeback_pkg::*;
#(
  parameter int LATE_FIFO_DEPTH = 4
) (
  input logic              clk_i,
  input logic              rst_i,
  riscv_writeback_if.slave wb
);

  wb_entry_t        late_in;
  wb_entry_t        head;
  wb_src_t          src;
  logic             exec_wr;
  logic             late_wr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             fifo_drop;
  logic             push;
  logic             pop;
  logic             retire_vld;
  logic [REG_W-1:0] retire_rd;
  logic [31:0]      pending;
  logic [31:0]      pending_nxt;
  logic             overflow;

  assign exec_wr = is_write(wb.exec_valid_i, wb.exec_rd_i);
  assign late_wr = is_write(wb.late_valid_i, wb.late_rd_i);
  assign late_in = '{rd: wb.late_rd_i, value: wb.late_value_i};

  always_comb begin
    src = SRC_NONE;
    if (exec_wr)
      src = SRC_EXEC;
    else if (!fifo_empty)
      src = SRC_FIFO;
    else if (late_wr)
      src = SRC_BYPASS;
  end

  always_comb begin
    wb.rd0_o       = RD_NONE;
    wb.rd0_value_o = '0;
    case (src)
      SRC_EXEC: begin
        wb.rd0_o       = wb.exec_rd_i;
        wb.rd0_value_o = wb.exec_value_i;
      end
      SRC_FIFO: begin
        wb.rd0_o       = head.rd;
        wb.rd0_value_o = head.value;
      end
      SRC_BYPASS: begin
        wb.rd0_o       = wb.late_rd_i;
        wb.rd0_value_o = wb.late_value_i;
      end
      default: ;
    endcase
  end

  assign pop  = (src == SRC_FIFO);
  assign push = late_wr && (src != SRC_BYPASS);

  riscv_wb_fifo #(
    .DEPTH (LATE_FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_late_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_vld (push),
    .push_dat (late_in),
    .pop_rdy  (pop),
    .pop_dat  (head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .drop     (fifo_drop)
  );

  assign retire_vld = (src == SRC_FIFO) || (src == SRC_BYPASS);
  assign retire_rd  = (src == SRC_FIFO) ? head.rd : wb.late_rd_i;

  // Issue is applied after retire so a same-register set wins; bit 0 never holds a pending write.
  always_comb begin
    pending_nxt = pending;
    if (retire_vld)
      pending_nxt[retire_rd] = 1'b0;
    if (wb.issue_valid_i)
      pending_nxt[wb.issue_rd_i] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pending  <= '0;
      overflow <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      overflow <= overflow | fifo_drop;
    end
  end

  assign wb.ra_busy_o = pending[wb.ra_i] && !(retire_vld && (retire_rd == wb.ra_i));
  assign wb.rb_busy_o = pending[wb.rb_i] && !(retire_vld && (retire_rd == wb.rb_i));

  assign wb.ra_value_o = ((wb.ra_i != RD_NONE) && (wb.rd0_o == wb.ra_i)) ? wb.rd0_value_o
                                                                          : wb.rf_ra_value_i;
  assign wb.rb_value_o = ((wb.rb_i != RD_NONE) && (wb.rd0_o == wb.rb_i)) ? wb.rd0_value_o
                                                                          : wb.rf_rb_value_i;

  assign wb.late_full_o = fifo_full;
  assign wb.overflow_o  = overflow;

endmodule

// File: tb/tb_riscv_writeback.sv
// Directed bench for riscv_writeback: single-cycle vector table plus multi-cycle sequences.
module tb_riscv_writeback;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk_i = ~clk_i;

  riscv_writeback_if wb_if ();

  riscv_writeback #(.LATE_FIFO_DEPTH(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .wb    (wb_if.slave)
  );

  typedef struct {
    logic        ev;
    logic [4:0]  erd;
    logic [31:0] eval;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] lval;
    logic [4:0]  ra;
    logic [31:0] rfa;
    logic [4:0]  rb;
    logic [31:0] rfb;
    logic [4:0]  x_rd0;
    logic [31:0] x_val;
    logic [31:0] x_ra;
    logic [31:0] x_rb;
    logic [4:0]  x_next_rd0;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    wb_if.exec_valid_i  = 1'b0;
    wb_if.exec_rd_i     = 5'd0;
    wb_if.exec_value_i  = 32'd0;
    wb_if.late_valid_i  = 1'b0;
    wb_if.late_rd_i     = 5'd0;
    wb_if.late_value_i  = 32'd0;
    wb_if.issue_valid_i = 1'b0;
    wb_if.issue_rd_i    = 5'd0;
  endtask

  task automatic exec_in(input logic v, input logic [4:0] rd, input logic [31:0] val);
    wb_if.exec_valid_i = v;
    wb_if.exec_rd_i    = rd;
    wb_if.exec_value_i = val;
  endtask

  task automatic late_in(input logic v, input logic [4:0] rd, input logic [31:0] val);
    wb_if.late_valid_i = v;
    wb_if.late_rd_i    = rd;
    wb_if.late_value_i = val;
  endtask

  task automatic issue(input logic v, input logic [4:0] rd);
    wb_if.issue_valid_i = v;
    wb_if.issue_rd_i    = rd;
  endtask

  task automatic pulse_reset();
    idle();
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd1,  32'hA,        1'b0, 5'd0,  32'h0,    5'd1,  32'h99,   5'd2,  32'h77,
                5'd1,  32'hA,        32'hA,    32'h77,       5'd0};
    vecs[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h1234, 5'd9,  32'h5,    5'd9,  32'h6,
                5'd9,  32'h1234,     32'h1234, 32'h1234,     5'd0};
    vecs[2] = '{1'b1, 5'd0,  32'hBAD,      1'b1, 5'd6,  32'h66,   5'd6,  32'h1,    5'd0,  32'h2,
                5'd6,  32'h66,       32'h66,   32'h2,        5'd0};
    vecs[3] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    5'd3,  32'h3,    5'd4,  32'h4,
                5'd0,  32'h0,        32'h3,    32'h4,        5'd0};
    vecs[4] = '{1'b0, 5'd5,  32'h55,       1'b0, 5'd12, 32'h12,   5'd5,  32'h50,   5'd12, 32'h120,
                5'd0,  32'h0,        32'h50,   32'h120,      5'd0};
    vecs[5] = '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd30, 32'h30,   5'd30, 32'hAAAA, 5'd31, 32'hBBBB,
                5'd31, 32'hFFFFFFFF, 32'hAAAA, 32'hFFFFFFFF, 5'd30};
    vecs[6] = '{1'b1, 5'd5,  32'h5,        1'b0, 5'd0,  32'h0,    5'd0,  32'h42,   5'd5,  32'h1,
                5'd5,  32'h5,        32'h42,   32'h5,        5'd0};

    idle();
    wb_if.ra_i = 5'd0;
    wb_if.rb_i = 5'd0;
    wb_if.rf_ra_value_i = 32'h0;
    wb_if.rf_rb_value_i = 32'h0;

    // Reset state
    wb_if.ra_i = 5'd3; wb_if.rf_ra_value_i = 32'hCAFE;
    repeat (3) tick();
    #2;
    chk("reset_rd0", 32'(wb_if.rd0_o), 32'd0);
    chk("reset_rd0_value", wb_if.rd0_value_o, 32'd0);
    chk("reset_late_full", 32'(wb_if.late_full_o), 32'd0);
    chk("reset_overflow", 32'(wb_if.overflow_o), 32'd0);
    chk("reset_ra_busy", 32'(wb_if.ra_busy_o), 32'd0);
    chk("reset_ra_value", wb_if.ra_value_o, 32'hCAFE);
    rst_i = 1'b1;
    tick();

    // Single-cycle vector table, each applied from an idle, drained state
    for (int i = 0; i < 7; i++) begin
      exec_in(vecs[i].ev, vecs[i].erd, vecs[i].eval);
      late_in(vecs[i].lv, vecs[i].lrd, vecs[i].lval);
      wb_if.ra_i = vecs[i].ra; wb_if.rf_ra_value_i = vecs[i].rfa;
      wb_if.rb_i = vecs[i].rb; wb_if.rf_rb_value_i = vecs[i].rfb;
      #2;
      chk($sformatf("vec%0d_rd0", i), 32'(wb_if.rd0_o), 32'(vecs[i].x_rd0));
      chk($sformatf("vec%0d_rd0_value", i), wb_if.rd0_value_o, vecs[i].x_val);
      chk($sformatf("vec%0d_ra_value", i), wb_if.ra_value_o, vecs[i].x_ra);
      chk($sformatf("vec%0d_rb_value", i), wb_if.rb_value_o, vecs[i].x_rb);
      tick();
      idle();
      #2;
      chk($sformatf("vec%0d_next_rd0", i), 32'(wb_if.rd0_o), 32'(vecs[i].x_next_rd0));
      tick();
      tick();
    end

    // 1: reset mid-traffic with 3 queued results and x5 pending
    wb_if.ra_i = 5'd5; wb_if.rf_ra_value_i = 32'h500;
    issue(1'b1, 5'd5);
    tick();
    issue(1'b0, 5'd0);
    for (int c = 0; c < 3; c++) begin
      exec_in(1'b1, 5'd1, 32'h10 + 32'(c));
      late_in(1'b1, 5'(8 + c), 32'h80 + 32'(c));
      tick();
    end
    idle();
    #2;
    chk("t1_busy_before_reset", 32'(wb_if.ra_busy_o), 32'd1);
    rst_i = 1'b0;
    #2;
    chk("t1_busy_async_clear", 32'(wb_if.ra_busy_o), 32'd0);
    tick();
    rst_i = 1'b1;
    #2;
    chk("t1_rd0_after_reset", 32'(wb_if.rd0_o), 32'd0);
    chk("t1_late_full_after_reset", 32'(wb_if.late_full_o), 32'd0);
    tick();
    #2;
    chk("t1_fifo_empty_after_reset", 32'(wb_if.rd0_o), 32'd0);
    tick();

    // 2: exec and late in the same cycle; late waits one cycle
    wb_if.ra_i = 5'd4; wb_if.rf_ra_value_i = 32'h400;
    issue(1'b1, 5'd4);
    tick();
    issue(1'b0, 5'd0);
    exec_in(1'b1, 5'd3, 32'h11);
    late_in(1'b1, 5'd4, 32'h22);
    #2;
    chk("t2_c0_rd0", 32'(wb_if.rd0_o), 32'd3);
    chk("t2_c0_value", wb_if.rd0_value_o, 32'h11);
    chk("t2_c0_x4_busy", 32'(wb_if.ra_busy_o), 32'd1);
    tick();
    idle();
    #2;
    chk("t2_c1_rd0", 32'(wb_if.rd0_o), 32'd4);
    chk("t2_c1_value", wb_if.rd0_value_o, 32'h22);
    chk("t2_c1_x4_busy", 32'(wb_if.ra_busy_o), 32'd0);
    chk("t2_c1_ra_fwd", wb_if.ra_value_o, 32'h22);
    tick();
    #2;
    chk("t2_c2_x4_busy", 32'(wb_if.ra_busy_o), 32'd0);
    chk("t2_c2_rd0", 32'(wb_if.rd0_o), 32'd0);
    tick();

    // 3 and 4: fill the FIFO behind exec; the second pass adds a 5th late result
    for (int pass = 0; pass < 2; pass++) begin
      pulse_reset();
      for (int c = 0; c < 6; c++) begin
        exec_in(1'b1, 5'(c + 1), 32'h100 + 32'(c));
        late_in(c < (pass == 0 ? 4 : 5), 5'(8 + c), 32'h80 + 32'(c));
        #2;
        chk($sformatf("p%0d_exec_c%0d", pass, c), 32'(wb_if.rd0_o), 32'(c + 1));
        if (c == 3) chk($sformatf("p%0d_full_c3", pass), 32'(wb_if.late_full_o), 32'd0);
        if (c >= 4) chk($sformatf("p%0d_full_c%0d", pass, c), 32'(wb_if.late_full_o), 32'd1);
        tick();
      end
      idle();
      #2;
      chk($sformatf("p%0d_overflow", pass), 32'(wb_if.overflow_o), pass == 0 ? 32'd0 : 32'd1);
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("p%0d_drain%0d_rd0", pass, k), 32'(wb_if.rd0_o), 32'(8 + k));
        chk($sformatf("p%0d_drain%0d_value", pass, k), wb_if.rd0_value_o, 32'h80 + 32'(k));
        if (k == 1) chk($sformatf("p%0d_full_drained", pass), 32'(wb_if.late_full_o), 32'd0);
        tick();
        #2;
      end
      chk($sformatf("p%0d_after_drain_rd0", pass), 32'(wb_if.rd0_o), 32'd0);
      chk($sformatf("p%0d_overflow_sticky", pass), 32'(wb_if.overflow_o),
          pass == 0 ? 32'd0 : 32'd1);
      tick();
    end
    pulse_reset();
    #2;
    chk("t4_overflow_reset", 32'(wb_if.overflow_o), 32'd0);
    tick();

    // 5: scoreboard and forwarding around a bypassed late write
    wb_if.ra_i = 5'd7; wb_if.rf_ra_value_i = 32'h700;
    wb_if.rb_i = 5'd7; wb_if.rf_rb_value_i = 32'h701;
    issue(1'b1, 5'd7);
    tick();
    issue(1'b0, 5'd0);
    #2;
    chk("t5_ra_busy", 32'(wb_if.ra_busy_o), 32'd1);
    chk("t5_rb_busy", 32'(wb_if.rb_busy_o), 32'd1);
    chk("t5_ra_rf", wb_if.ra_value_o, 32'h700);
    tick();
    #2;
    chk("t5_ra_busy_hold", 32'(wb_if.ra_busy_o), 32'd1);
    late_in(1'b1, 5'd7, 32'hAB);
    #2;
    chk("t5_retire_rd0", 32'(wb_if.rd0_o), 32'd7);
    chk("t5_retire_ra_busy", 32'(wb_if.ra_busy_o), 32'd0);
    chk("t5_retire_rb_busy", 32'(wb_if.rb_busy_o), 32'd0);
    chk("t5_retire_ra_fwd", wb_if.ra_value_o, 32'hAB);
    tick();
    idle();
    #2;
    chk("t5_after_busy", 32'(wb_if.ra_busy_o), 32'd0);
    chk("t5_after_ra_rf", wb_if.ra_value_o, 32'h700);
    issue(1'b1, 5'd7);
    tick();
    issue(1'b0, 5'd0);
    late_in(1'b1, 5'd7, 32'hCD);
    issue(1'b1, 5'd7);
    #2;
    chk("t5_setclr_same_cycle_busy", 32'(wb_if.ra_busy_o), 32'd0);
    chk("t5_setclr_rd0_value", wb_if.rd0_value_o, 32'hCD);
    tick();
    idle();
    #2;
    chk("t5_set_wins", 32'(wb_if.ra_busy_o), 32'd1);
    late_in(1'b1, 5'd7, 32'hEE);
    tick();
    idle();
    #2;
    chk("t5_final_clear", 32'(wb_if.ra_busy_o), 32'd0);
    tick();

    // 6: writes to x0 are discarded everywhere
    wb_if.ra_i = 5'd0; wb_if.rf_ra_value_i = 32'h1234;
    exec_in(1'b1, 5'd0, 32'hFF);
    late_in(1'b1, 5'd0, 32'h55);
    issue(1'b1, 5'd0);
    #2;
    chk("t6_rd0", 32'(wb_if.rd0_o), 32'd0);
    chk("t6_rd0_value", wb_if.rd0_value_o, 32'd0);
    chk("t6_ra_value", wb_if.ra_value_o, 32'h1234);
    chk("t6_ra_busy", 32'(wb_if.ra_busy_o), 32'd0);
    tick();
    idle();
    #2;
    chk("t6_nothing_queued", 32'(wb_if.rd0_o), 32'd0);
    chk("t6_ra_busy_after", 32'(wb_if.ra_busy_o), 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
